// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and small op-decoding helpers.
package mul_div_unit_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } mdu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10,
      ST_DONE = 2'b11
   } mdu_state_t;

   function automatic logic op_is_div(input mdu_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input mdu_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle of the multiply/divide unit; the FSM state is
// carried alongside for observation.
interface mul_div_unit_if #(parameter int WIDTH = 32);
   import mul_div_unit_pkg::*;

   // Handshake: start is sampled only while the unit is idle (busy=0 and
   // not in DONE); done pulses for one cycle when hi/lo/div_by_zero are
   // updated, and those outputs then hold until the next done.
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;
   mdu_state_t       state;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, div_by_zero, state
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, div_by_zero, state
   );

endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement negator: dout = en ? -din : din.
module mdu_negate #(
   parameter int W = 32
) (
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   assign dout = en ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/mul_div_unit.sv
// Radix-2 iterative multiply/divide unit: sign-magnitude operands, one
// shift-add or restoring shift-subtract step per cycle, sign fix-up at the end.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic           clk,
   input  logic           reset,
   mul_div_unit_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   mdu_state_t       state_q, state_d;
   mdu_op_t          op_q, op_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_lo_q, neg_lo_d;
   logic             neg_hi_q, neg_hi_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic             dbz_pend_q, dbz_pend_d;

   mdu_op_t          in_op;
   logic             in_div, in_signed, a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;

   assign in_op     = mdu_op_t'(bus.op);
   assign in_div    = op_is_div(in_op);
   assign in_signed = op_is_signed(in_op);
   assign a_neg     = in_signed & bus.a[WIDTH-1];
   assign b_neg     = in_signed & bus.b[WIDTH-1];

   mdu_negate #(.W(WIDTH)) u_abs_a (.en(a_neg), .din(bus.a), .dout(a_abs));
   mdu_negate #(.W(WIDTH)) u_abs_b (.en(b_neg), .din(bus.b), .dout(b_abs));

   // One WIDTH+1-bit adder serves both ops; the extra top bit of add_res is
   // the carry, which for a subtraction means "no borrow" (quotient bit 1).
   logic [WIDTH:0]   add_x, add_y;
   logic             add_sub;
   logic [WIDTH+1:0] add_res;
   logic             no_borrow;
   logic [WIDTH-1:0] step_hi, step_lo;

   always_comb begin
      add_x   = {1'b0, acc_hi_q};
      add_y   = '0;
      add_sub = 1'b0;
      if (op_is_div(op_q)) begin
         add_x   = {acc_hi_q, acc_lo_q[WIDTH-1]};
         add_y   = {1'b0, opnd_q};
         add_sub = 1'b1;
      end else if (acc_lo_q[0]) begin
         add_y = {1'b0, opnd_q};
      end
      add_res = {1'b0, add_x}
              + {1'b0, (add_sub ? ~add_y : add_y)}
              + {{(WIDTH+1){1'b0}}, add_sub};
   end

   assign no_borrow = add_res[WIDTH+1];

   always_comb begin
      if (op_is_div(op_q)) begin
         step_hi = no_borrow ? add_res[WIDTH-1:0] : add_x[WIDTH-1:0];
         step_lo = {acc_lo_q[WIDTH-2:0], no_borrow};
      end else begin
         step_hi = add_res[WIDTH:1];
         step_lo = {add_res[0], acc_lo_q[WIDTH-1:1]};
      end
   end

   // Sign correction: the product is negated as one 2*WIDTH-bit value, the
   // quotient and remainder independently.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   mdu_negate #(.W(2*WIDTH)) u_fix_prod (
      .en(neg_lo_q), .din({acc_hi_q, acc_lo_q}), .dout(prod_fix));
   mdu_negate #(.W(WIDTH)) u_fix_quot (
      .en(neg_lo_q), .din(acc_lo_q), .dout(quot_fix));
   mdu_negate #(.W(WIDTH)) u_fix_rem (
      .en(neg_hi_q), .din(acc_hi_q), .dout(rem_fix));

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      acc_hi_d   = acc_hi_q;
      acc_lo_d   = acc_lo_q;
      opnd_d     = opnd_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      cnt_d      = cnt_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      done_d     = 1'b0;
      dbz_d      = dbz_q;
      dbz_pend_d = dbz_pend_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               op_d  = in_op;
               cnt_d = CNT_INIT;
               dbz_d = 1'b0;
               if (in_div && (bus.b == '0)) begin
                  // Divide by zero skips iteration; FIX passes values through.
                  acc_hi_d   = bus.a;
                  acc_lo_d   = '1;
                  opnd_d     = '0;
                  neg_lo_d   = 1'b0;
                  neg_hi_d   = 1'b0;
                  dbz_pend_d = 1'b1;
                  state_d    = ST_FIX;
               end else begin
                  acc_hi_d   = '0;
                  acc_lo_d   = a_abs;
                  opnd_d     = b_abs;
                  neg_lo_d   = a_neg ^ b_neg;
                  neg_hi_d   = in_div & a_neg;
                  dbz_pend_d = 1'b0;
                  state_d    = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            acc_hi_d = step_hi;
            acc_lo_d = step_lo;
            cnt_d    = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = ST_FIX;
         end
         ST_FIX: begin
            if (op_is_div(op_q)) begin
               acc_hi_d = rem_fix;
               acc_lo_d = quot_fix;
            end else begin
               {acc_hi_d, acc_lo_d} = prod_fix;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            hi_d    = acc_hi_q;
            lo_d    = acc_lo_q;
            dbz_d   = dbz_pend_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_MULT;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         opnd_q     <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         cnt_q      <= '0;
         neg_lo_q   <= 1'b0;
         neg_hi_q   <= 1'b0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         dbz_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         acc_hi_q   <= acc_hi_d;
         acc_lo_q   <= acc_lo_d;
         opnd_q     <= opnd_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         cnt_q      <= cnt_d;
         neg_lo_q   <= neg_lo_d;
         neg_hi_q   <= neg_hi_d;
         done_q     <= done_d;
         dbz_q      <= dbz_d;
         dbz_pend_q <= dbz_pend_d;
      end
   end

   assign bus.busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
   assign bus.done        = done_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (WIDTH=32): a driver issues
// operations and queues expected results; a monitor checks each done pulse.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   localparam int W = 32;

   logic clk;
   logic reset;
   int   cyc;
   int   vectors;
   int   errors;

   logic [2*W:0] exp_q[$];
   int           lat_q[$];
   int           acc_q[$];
   logic [W-1:0] held_hi, held_lo;

   mul_div_unit_if #(.WIDTH(W)) bus ();

   mul_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end expected end");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (reset) begin
         held_hi = '0;
         held_lo = '0;
      end else if (bus.done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", bus.done, 1'b0);
         end else begin
            logic [2*W:0] e;
            int lat, acc;
            e   = exp_q.pop_front();
            lat = lat_q.pop_front();
            acc = acc_q.pop_front();
            check("lo", bus.lo, e[W-1:0]);
            check("hi", bus.hi, e[2*W-1:W]);
            check("div_by_zero", bus.div_by_zero, e[2*W]);
            check("latency", cyc - acc, lat);
            held_hi = e[2*W-1:W];
            held_lo = e[W-1:0];
         end
      end else if ((bus.hi !== held_hi) || (bus.lo !== held_lo)) begin
         check("hold_hi_lo", {bus.hi, bus.lo}, {held_hi, held_lo});
         held_hi = bus.hi;
         held_lo = bus.lo;
      end
   end

   // ---------------- driver ----------------
   // Issues one operation, scrambles the operand inputs after acceptance,
   // optionally pulses a stray start, and waits (bounded) for done.
   task automatic issue(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo,
                        input logic e_dbz, input int lat, input int pulse_at);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      exp_q.push_back({e_dbz, e_hi, e_lo});
      lat_q.push_back(lat);
      @(posedge clk);
      #1;
      acc_q.push_back(cyc);
      check("busy_after_accept", bus.busy, 1'b1);
      check("dbz_cleared_on_accept", bus.div_by_zero, 1'b0);
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         bus.start = (i == pulse_at);
         if (i == 1) begin
            bus.op = 2'($urandom_range(0, 3));
            bus.a  = $urandom;
            bus.b  = $urandom;
         end
         if (i == pulse_at) begin
            bus.op = OP_DIVU;
            bus.a  = 32'd100;
            bus.b  = '0;
         end
         if (bus.done) break;
      end
      bus.start = 1'b0;
      check("done_seen", bus.done, 1'b1);
   endtask

   localparam int LAT = W + 2;

   initial begin
      cyc       = 0;
      vectors   = 0;
      errors    = 0;
      held_hi   = '0;
      held_lo   = '0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = OP_MULT;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check("rst_state", bus.state, ST_IDLE);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_hi", bus.hi, '0);
      check("rst_lo", bus.lo, '0);
      check("rst_dbz", bus.div_by_zero, 1'b0);
      reset = 1'b0;

      issue(OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, LAT, -1);
      issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT, -1);
      issue(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT, -1);
      issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT, -1);
      issue(OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1, 2,   -1);
      // The flag must persist while idle.
      repeat (3) @(negedge clk);
      check("dbz_held", bus.div_by_zero, 1'b1);
      issue(OP_MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0, LAT, -1);
      issue(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, LAT, -1);
      issue(OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, LAT, -1);
      issue(OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, LAT, -1);
      issue(OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, LAT, -1);
      issue(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, LAT, -1);
      issue(OP_MULT,  32'hFFFFFFF9, 32'hFFFFFFFA, 32'h00000000, 32'h0000002A, 1'b0, LAT, -1);
      issue(OP_MULT,  32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, LAT, -1);
      issue(OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 2,   -1);
      // Stray start (DIVU by zero) while busy must be ignored.
      issue(OP_MULTU, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A, 1'b0, LAT, 5);

      // Abort a MULT with reset at cycle 10.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.a     = 32'hFFFFFFF0;
      bus.b     = 32'h00000011;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      check("busy_before_abort", bus.busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("abort_state", bus.state, ST_IDLE);
      check("abort_busy", bus.busy, 1'b0);
      check("abort_done", bus.done, 1'b0);
      check("abort_hi", bus.hi, '0);
      check("abort_lo", bus.lo, '0);
      check("abort_dbz", bus.div_by_zero, 1'b0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      issue(OP_MULTU, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0, LAT, -1);

      repeat (40) @(negedge clk);
      check("pending_results", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; SHALL support any even value from 8 to 64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of the iteration counter.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to begin an operation; sampled only in IDLE.
REQ-006 op  in  2  operation code: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 a  in  WIDTH  multiplicand or dividend.
REQ-008 b  in  WIDTH  multiplier or divisor.
REQ-009 busy  out  1  high while an operation is in progress.
REQ-010 done  out  1  one-cycle pulse when hi/lo become valid.
REQ-011 hi  out  WIDTH  product upper half or remainder.
REQ-012 lo  out  WIDTH  product lower half or quotient.
REQ-013 div_by_zero  out  1  set with done when DIV/DIVU had b==0; held until next accepted start.

Function
REQ-014 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-015 IDLE: start=1 SHALL latch op, |a|, |b| (signed ops) or raw a, b (unsigned ops), and the result signs; load counter=WIDTH; go to CALC.
REQ-016 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide; decrement counter; go to FIX after the WIDTH-th step.
REQ-017 FIX SHALL two's-complement-negate the product if exactly one operand was negative; negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
REQ-018 DIV/DIVU with b==0 SHALL bypass CALC, go straight to FIX, and give lo = all ones, hi = a, div_by_zero=1.
REQ-019 DONE SHALL assert done for exactly one cycle, write hi/lo, and return to IDLE.
REQ-020 Latency: done SHALL rise WIDTH+2 edges after the accepting edge (2 edges for divide by zero).
REQ-021 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-022 start SHALL be ignored while busy=1 or in DONE; operands changed after acceptance SHALL NOT affect the result.
REQ-023 hi/lo SHALL hold their last value from done until the next done; they SHALL NOT change mid-operation.
REQ-024 Signed division SHALL truncate toward zero; remainder takes the sign of the dividend.
REQ-025 Signed MIN / -1 SHALL give lo = MIN, hi = 0, with no flag.
REQ-026 Multiply SHALL produce the full 2*WIDTH-bit product; it SHALL NOT overflow.

Reset
REQ-027 Reset SHALL force state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
REQ-028 Reset asserted mid-operation SHALL abort it with no done pulse; a start on the first edge after deassertion SHALL be accepted.

Structure
REQ-029 A shared package SHALL hold the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state typedef.
REQ-030 A sub-module mdu_negate (parametrised conditional two's-complement negator) SHALL be used for operand absolute value and FIX-stage correction.
REQ-031 The datapath SHALL use one shared WIDTH+1-bit adder/subtractor for both multiply and divide.

Verification (WIDTH=32)
REQ-032 MULT a=FFFFFFFD (-3), b=00000005 -> done at edge 34, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-033 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-034 DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-035 DIVU a=00000064, b=0 -> done 2 edges after start, div_by_zero=1, lo=FFFFFFFF, hi=00000064.
REQ-036 MULTU 7*6 with a second start (op=DIVU) pulsed at cycle 5 -> second start ignored, hi=0, lo=0000002A, single done.
REQ-037 Reset asserted at cycle 10 of a MULT -> no done, busy=0, hi=lo=0; new MULTU 2*3 started right after release -> lo=6.
